mem_port_arbiter: RTL

- Shares one single-ported unified memory between the instruction-fetch requester and the data-memory requester of the CPU.
- Sequences each access as a multi-cycle transaction against a memory with fixed read latency.
- Returns read data and a one-cycle completion pulse to the winning requester.
- Drives per-requester stall signals that freeze the PC / pipeline while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between
// the instruction-fetch and data-memory requesters, one transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              dm_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e            state_q, state_d;
    logic [3:0]        busy_q, busy_d, starve_q, starve_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              any_req, dm_win, last_beat, win;

    assign any_req   = if_req_i | dm_req_i;
    // data wins ties until fetch has lost STARVE_MAX ties in a row
    assign dm_win    = dm_req_i & (~if_req_i | (starve_q < 4'(STARVE_MAX)));
    assign last_beat = (busy_q == 4'd0);
    assign win       = (state_q == IDLE) & any_req;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            busy_q     <= '0;
            starve_q   <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            if_gnt_q   <= 1'b0;
            dm_gnt_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            if_gnt_q   <= if_gnt_d;
            dm_gnt_q   <= dm_gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (any_req ? BUSY : IDLE) :
                  (state_q == BUSY) ? (last_beat ? RESP : BUSY) : IDLE;
    end

    always_comb begin
        busy_d     = busy_q;
        starve_d   = starve_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_gnt_d   = win & ~dm_win;
        dm_gnt_d   = win & dm_win;
        if (win) begin
            owner_d  = dm_win;
            we_d     = dm_win & dm_we_i;
            addr_d   = dm_win ? dm_addr_i : if_addr_i;
            wdata_d  = (dm_win & dm_we_i) ? dm_wdata_i : wdata_q;
            busy_d   = 4'(MEM_LAT - 1);
            starve_d = !dm_win ? 4'd0 :
                       (if_req_i && starve_q < 4'(STARVE_MAX)) ? starve_q + 4'd1 : starve_q;
        end else if (state_q == BUSY) begin
            busy_d     = last_beat ? 4'd0 : busy_q - 4'd1;
            if_rdata_d = (last_beat & ~we_q & ~owner_q) ? mem_rdata_i : if_rdata_q;
            dm_rdata_d = (last_beat & ~we_q & owner_q) ? mem_rdata_i : dm_rdata_q;
        end
    end

    always_comb begin
        if_gnt_o    = if_gnt_q;
        dm_gnt_o    = dm_gnt_q;
        if_valid_o  = (state_q == RESP) & ~owner_q;
        dm_valid_o  = (state_q == RESP) & owner_q;
        if_stall_o  = if_req_i & ~if_valid_o;
        dm_stall_o  = dm_req_i & ~dm_valid_o;
        mem_read_o  = (state_q == BUSY) & ~we_q;
        mem_write_o = (state_q == BUSY) & we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if_rdata_o  = if_rdata_q;
        dm_rdata_o  = dm_rdata_q;
    end
endmodule
